// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, draw-mode encodings, FSM state types and the init command table
package lcd_pkg;
  localparam logic [7:0] CMD_FUNC_8B_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [7:0] LINE2_OFS = 8'h40;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  typedef enum logic [1:0] {MODE_LOAD, MODE_PLACE, MODE_CLEAR, MODE_RSVD} draw_mode_t;
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, LOAD_ADDR, LOAD_DATA, PLACE_CURSOR, PLACE_CHAR, DONE} state_t;
  typedef enum logic [2:0] {P_IDLE, P_ARM, P_SETUP, P_PULSE, P_HOLD, P_CLR} phy_state_t;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC_8B_2L : i == 2'd1 ? CMD_DISP_ON : i == 2'd2 ? CMD_ENTRY_INC : CMD_CLEAR;
  endfunction
endpackage

// File: rtl/lcd_sprite_ctrl_if.sv
// lcd_sprite_ctrl_if: request/done handshake, ROM read port and LCD pins; master = pet logic side, slave = controller
interface lcd_sprite_ctrl_if #(parameter int AW = 6);
  logic draw_req;
  logic [1:0] draw_mode;
  logic [3:0] draw_col;
  logic busy;
  logic draw_done;
  logic init_done;
  logic [AW-1:0] rom_addr;
  logic [7:0] rom_data;
  logic lcd_rs;
  logic lcd_rw;
  logic lcd_en;
  logic [7:0] lcd_data;
  modport master(output draw_req, draw_mode, draw_col, rom_data,
                 input busy, draw_done, init_done, rom_addr, lcd_rs, lcd_rw, lcd_en, lcd_data);
  modport slave(input draw_req, draw_mode, draw_col, rom_data,
                output busy, draw_done, init_done, rom_addr, lcd_rs, lcd_rw, lcd_en, lcd_data);
endinterface

// File: rtl/lcd_write_phy.sv
// lcd_write_phy: tick-timed 3-phase byte strobe (setup/pulse/hold) plus post-clear wait; in tick,start,rs_in,data_in,is_clear; out lcd_rs,lcd_en,lcd_data,wr_done,idle
module lcd_write_phy
  import lcd_pkg::*;
#(
  parameter int CLEAR_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  input  logic       is_clear,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       wr_done,
  output logic       idle
);
  phy_state_t st_q, st_d;
  logic rs_q, rs_d, clr_q, clr_d, rdy;
  logic [7:0] data_q, data_d, cnt_q, cnt_d;
  always_comb begin
    wr_done = tick && ((st_q == P_HOLD && (!clr_q || CLEAR_TICKS == 0)) ||
                       (st_q == P_CLR && cnt_q == 8'(CLEAR_TICKS - 1)));
    rdy = st_q == P_IDLE || wr_done;
    st_d = st_q;
    rs_d = rs_q;
    data_d = data_q;
    clr_d = clr_q;
    cnt_d = cnt_q;
    if (start && rdy) begin
      st_d = st_q == P_IDLE ? P_ARM : P_SETUP;
      rs_d = rs_in;
      data_d = data_in;
      clr_d = is_clear;
    end else if (wr_done) begin
      st_d = P_IDLE;
    end else if (tick) begin
      st_d = st_q == P_ARM ? P_SETUP : st_q == P_SETUP ? P_PULSE : st_q == P_PULSE ? P_HOLD :
             st_q == P_HOLD ? P_CLR : st_q;
      cnt_d = st_q == P_CLR ? cnt_q + 8'd1 : 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= P_IDLE;
      rs_q <= 1'b0;
      data_q <= 8'h00;
      clr_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      st_q <= st_d;
      rs_q <= rs_d;
      data_q <= data_d;
      clr_q <= clr_d;
      cnt_q <= cnt_d;
    end
  end
  assign lcd_rs = rs_q;
  assign lcd_data = data_q;
  assign lcd_en = st_q == P_PULSE;
  assign idle = st_q == P_IDLE;
endmodule

// File: rtl/lcd_sprite_ctrl.sv
// lcd_sprite_ctrl: HD44780 init + sprite load/place/clear sequencer; ports clk, reset, bus (draw req/done, ROM port, LCD pins)
module lcd_sprite_ctrl
  import lcd_pkg::*;
#(
  parameter int TICK_DIV = 20000,
  parameter int NUM_GLYPHS = 8,
  parameter int GRID_COLS = 4,
  parameter int POWERUP_TICKS = 100,
  parameter int CLEAR_TICKS = 5
) (
  input logic clk,
  input logic reset,
  lcd_sprite_ctrl_if.slave bus
);
  localparam int ROWS = NUM_GLYPHS / GRID_COLS;
  localparam int NB = NUM_GLYPHS * 8;
  localparam int AW = $clog2(NB);
  localparam int MAX_COL = 16 - GRID_COLS;
  state_t state_q, state_d;
  draw_mode_t mode_q, mode_d, req_mode;
  logic [31:0] div_q, div_d, pwr_q, pwr_d;
  logic [7:0] idx_q, idx_d, wr_data;
  logic [3:0] col_q, col_d;
  logic row_q, row_d, busy_q, busy_d, done_q, done_d, init_q, init_d;
  logic tick, start, wr_rs, wr_done, phy_idle, rdy;
  assign tick = div_q == 32'(TICK_DIV - 1);
  assign req_mode = draw_mode_t'(bus.draw_mode);
  // the next byte may be handed over on the very tick the current one finishes
  assign rdy = phy_idle || wr_done;
  always_comb begin
    div_d = tick ? 32'd0 : div_q + 32'd1;
    state_d = state_q;
    mode_d = mode_q;
    pwr_d = pwr_q;
    idx_d = idx_q;
    col_d = col_q;
    row_d = row_q;
    busy_d = busy_q;
    done_d = 1'b0;
    init_d = init_q;
    start = 1'b0;
    wr_rs = 1'b0;
    wr_data = 8'h00;
    case (state_q)
      PWR_WAIT: if (tick) begin
        pwr_d = pwr_q + 32'd1;
        if (pwr_q == 32'(POWERUP_TICKS - 1)) begin
          state_d = INIT;
          idx_d = 8'd0;
        end
      end
      INIT: begin
        wr_data = init_cmd(idx_q[1:0]);
        start = idx_q < 8'd4 && rdy;
        if (start) idx_d = idx_q + 8'd1;
        else if (idx_q == 8'd4 && phy_idle) begin
          state_d = IDLE;
          init_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      IDLE: if (bus.draw_req && !done_q) begin
        mode_d = req_mode;
        col_d = bus.draw_col > 4'(MAX_COL) ? 4'(MAX_COL) : bus.draw_col;
        idx_d = 8'd0;
        row_d = 1'b0;
        busy_d = req_mode != MODE_RSVD;
        done_d = req_mode == MODE_RSVD;
        state_d = req_mode == MODE_LOAD ? LOAD_ADDR : req_mode == MODE_RSVD ? IDLE : PLACE_CURSOR;
      end
      LOAD_ADDR: begin
        wr_data = CMD_CGRAM;
        start = rdy;
        if (rdy) state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        wr_rs = 1'b1;
        wr_data = bus.rom_data;
        start = rdy;
        if (rdy) begin
          idx_d = idx_q == 8'(NB - 1) ? 8'd0 : idx_q + 8'd1;
          if (idx_q == 8'(NB - 1)) state_d = PLACE_CURSOR;
        end
      end
      PLACE_CURSOR: begin
        wr_data = CMD_DDRAM | ((row_q ? LINE2_OFS : 8'h00) + 8'(col_q));
        start = rdy;
        if (rdy) begin
          state_d = PLACE_CHAR;
          idx_d = 8'd0;
        end
      end
      PLACE_CHAR: begin
        wr_rs = 1'b1;
        wr_data = mode_q == MODE_CLEAR ? CHAR_SPACE : (row_q ? 8'(GRID_COLS) : 8'h00) + idx_q;
        start = rdy;
        if (rdy) begin
          idx_d = idx_q == 8'(GRID_COLS - 1) ? 8'd0 : idx_q + 8'd1;
          if (idx_q == 8'(GRID_COLS - 1)) begin
            state_d = int'(row_q) == ROWS - 1 ? DONE : PLACE_CURSOR;
            row_d = 1'b1;
          end
        end
      end
      DONE: if (phy_idle) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = PWR_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PWR_WAIT;
      mode_q <= MODE_LOAD;
      div_q <= 32'd0;
      pwr_q <= 32'd0;
      idx_q <= 8'd0;
      col_q <= 4'd0;
      row_q <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      div_q <= div_d;
      pwr_q <= pwr_d;
      idx_q <= idx_d;
      col_q <= col_d;
      row_q <= row_d;
      busy_q <= busy_d;
      done_q <= done_d;
      init_q <= init_d;
    end
  end
  lcd_write_phy #(.CLEAR_TICKS(CLEAR_TICKS)) u_phy (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .start(start),
    .rs_in(wr_rs),
    .data_in(wr_data),
    .is_clear(!wr_rs && wr_data == CMD_CLEAR),
    .lcd_rs(bus.lcd_rs),
    .lcd_en(bus.lcd_en),
    .lcd_data(bus.lcd_data),
    .wr_done(wr_done),
    .idle(phy_idle)
  );
  assign bus.busy = busy_q;
  assign bus.draw_done = done_q;
  assign bus.init_done = init_q;
  assign bus.lcd_rw = 1'b0;
  assign bus.rom_addr = state_q == LOAD_DATA ? AW'(idx_q) : '0;
endmodule

// File: tb/tb_lcd_sprite_ctrl.sv
// tb_lcd_sprite_ctrl: randomized self-checking bench comparing every LCD strobe against a byte-list model
module tb_lcd_sprite_ctrl;
  localparam int TD = 2, PT = 4, CT = 2, NG = 8, GC = 4, ROWS = NG / GC, NB = NG * 8, AW = $clog2(NB);
  logic clk = 1'b0, reset = 1'b1;
  lcd_sprite_ctrl_if #(.AW(AW)) bus();
  lcd_sprite_ctrl #(.TICK_DIV(TD), .NUM_GLYPHS(NG), .GRID_COLS(GC), .POWERUP_TICKS(PT), .CLEAR_TICKS(CT))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [7:0] rom[NB];
  logic [8:0] exp_q[$];
  logic [8:0] mq[$];
  int n_strobe = 0, done_cnt = 0, cyc = 0, last_fall = 0;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
    end
  endtask

  // expected {rs,data} byte list for one request, straight from the byte-order rules
  function automatic void build(input int mode, input int col);
    int c;
    mq.delete();
    if (mode == 3) return;
    c = col > 16 - GC ? 16 - GC : col;
    if (mode == 0) begin
      mq.push_back(9'h040);
      for (int i = 0; i < NB; i++) mq.push_back({1'b1, rom[i]});
    end
    for (int r = 0; r < ROWS; r++) begin
      mq.push_back({1'b0, 8'(8'h80 + r * 8'h40 + c)});
      for (int k = 0; k < GC; k++) mq.push_back({1'b1, mode == 2 ? 8'h20 : 8'(r * GC + k)});
    end
  endfunction

  // strobe monitor: byte order, setup/hold stability, pulse width
  logic en_p = 1'b0;
  logic [8:0] bus_p = 9'h0;
  int hi_len = 0, since_chg = 0, since_fall = 1000;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      en_p = bus.lcd_en;
      bus_p = {bus.lcd_rs, bus.lcd_data};
      hi_len = 0;
      since_chg = 0;
      since_fall = 1000;
    end else begin
      since_fall++;
      since_chg++;
      if ({bus.lcd_rs, bus.lcd_data} !== bus_p) begin
        check("rs/data stable while en high", bus.lcd_en, 0);
        check_range("rs/data hold after en falls", since_fall, TD, 1 << 30);
        since_chg = 0;
      end
      if (bus.lcd_en && !en_p) begin
        n_strobe++;
        check_range("rs/data setup before en", since_chg, TD, 1 << 30);
        check("rw tied low", bus.lcd_rw, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected strobe: got %0h, want none", {bus.lcd_rs, bus.lcd_data});
        end else check("strobe byte", {bus.lcd_rs, bus.lcd_data}, exp_q.pop_front());
      end
      if (bus.lcd_en) hi_len++;
      if (!bus.lcd_en && en_p) begin
        check("en high width", hi_len, TD);
        hi_len = 0;
        since_fall = 0;
        last_fall = cyc;
      end
      en_p = bus.lcd_en;
      bus_p = {bus.lcd_rs, bus.lcd_data};
    end
    if (bus.draw_done) done_cnt++;
  end

  task automatic reset_checks();
    check("rst lcd_en", bus.lcd_en, 0);
    check("rst lcd_rs", bus.lcd_rs, 0);
    check("rst lcd_data", bus.lcd_data, 0);
    check("rst rom_addr", bus.rom_addr, 0);
    check("rst draw_done", bus.draw_done, 0);
    check("rst init_done", bus.init_done, 0);
    check("rst busy", bus.busy, 1);
  endtask

  task automatic run_init();
    bit seen = 0;
    logic busy_prev = 1'b1;
    exp_q.delete();
    foreach (mq[i]) mq.delete();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < (PT + 16 + CT + 4) * TD + 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.init_done) begin
        seen = 1;
        check("busy falls with init_done", bus.busy, 0);
        check("busy high before init_done", busy_prev, 1);
        check_range("init_done after clear wait", cyc - last_fall, TD * (1 + CT), TD * (2 + CT) + 1);
      end
      busy_prev = bus.busy;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL init timeout: init_done=%0b, want 1", bus.init_done);
    end
    check("init strobes consumed", exp_q.size(), 0);
  endtask

  task automatic do_op(input int mode, input int col, input bit extra, input bit same_clk);
    int s0, nexp, budget;
    bit seen;
    @(posedge clk);
    #1;
    check("idle before req", bus.busy, 0);
    build(mode, col);
    nexp = mq.size();
    foreach (mq[i]) exp_q.push_back(mq[i]);
    done_cnt = 0;
    s0 = n_strobe;
    seen = 0;
    bus.draw_req = 1'b1;
    bus.draw_mode = 2'(mode);
    bus.draw_col = 4'(col);
    @(posedge clk);
    #1 bus.draw_req = 1'b0;
    @(negedge clk);
    if (mode == 3) begin
      check("reserved mode done next clk", bus.draw_done, 1);
      check("reserved mode not busy", bus.busy, 0);
      seen = 1;
    end else begin
      check("busy after req", bus.busy, 1);
      budget = (nexp * 3 + 8) * TD + 20;
      for (int i = 0; i < budget && !seen; i++) begin
        @(posedge clk);
        #1;
        bus.draw_req = extra && i == budget / 4;
        bus.draw_mode = 2'($urandom_range(0, 3));
        bus.draw_col = 4'($urandom_range(0, 15));
        @(negedge clk);
        if (bus.draw_done) begin
          seen = 1;
          check("busy low at draw_done", bus.busy, 0);
          if (same_clk) begin
            bus.draw_req = 1'b1;
            bus.draw_mode = 2'd1;
          end
        end
      end
      @(posedge clk);
      #1 bus.draw_req = 1'b0;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL draw_done timeout mode %0d: got no pulse, want one", mode);
    end
    repeat (12 * TD) @(negedge clk);
    check("one draw_done pulse", done_cnt, 1);
    check("all bytes strobed", exp_q.size(), 0);
    check("strobe count", n_strobe - s0, nexp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int s0;
    bit hit;
    bus.draw_req = 1'b0;
    bus.draw_mode = 2'd0;
    bus.draw_col = 4'd0;
    for (int i = 0; i < NB; i++) rom[i] = 8'(i);
    build(0, 0);
    check("model mode0 byte count", mq.size(), 75);
    check("model mode0 last byte", mq[74], 9'h107);
    build(1, 14);
    check("model mode1 byte count", mq.size(), 10);
    check("model clamped cursor", mq[0], 9'h08C);
    check("model row2 cursor", mq[5], 9'h0CC);
    build(2, 5);
    check("model clear space", mq[1], 9'h120);
    check("model clear row2 cursor", mq[5], 9'h0C5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    run_init();
    do_op(0, 0, 1, 0);
    do_op(1, 14, 0, 1);
    do_op(2, 5, 1, 0);
    do_op(3, 0, 0, 0);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NB; i++) rom[i] = 8'($urandom_range(0, 255));
      do_op($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < NB; i++) rom[i] = 8'(i);
    build(0, 3);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    s0 = n_strobe;
    hit = 0;
    @(posedge clk);
    #1;
    bus.draw_req = 1'b1;
    bus.draw_mode = 2'd0;
    bus.draw_col = 4'd3;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk);
      #1 bus.draw_req = i == 20;
      bus.draw_mode = 2'd1;
      hit = n_strobe - s0 >= 20;
    end
    check("reached mid LOAD_DATA", hit, 1);
    reset = 1'b1;
    bus.draw_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    run_init();
    do_op(1, 3, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
